snax_hwpe_to_reqrsp_mc: RTL

- Multi-channel bridge from NumChannels HWPE TCDM slave ports (32-bit word protocol) to NumChannels reqrsp TCDM request/response ports.
- Each channel has its own request FIFO, full byte-enable lane steering into a DataWidth bus, and an outstanding-transaction tracker that routes read data back from the correct lane.
- Sits between a SNAX accelerator's HWPE streamer and the cluster TCDM interconnect.

---
 rtl/snax_hwpe_reqrsp_pkg.sv | 68 ++++++
 rtl/hwpe_stream_intf_tcdm.sv | 14 +
 rtl/fifo_v3.sv | 53 +++++
 rtl/snax_hwpe_to_reqrsp_chan.sv | 120 ++++++++++++
 rtl/snax_hwpe_to_reqrsp_mc.sv | 47 ++++
 5 files changed

// File: rtl/snax_hwpe_reqrsp_pkg.sv
// Shared widths, default reqrsp TCDM types and lane helpers for the HWPE-to-reqrsp bridge.
// Lane helpers assume DataWidth/32 is a power of two.
package snax_hwpe_reqrsp_pkg;

    localparam int unsigned HwpeAddrWidth = 32;
    localparam int unsigned HwpeDataWidth = 32;
    localparam int unsigned MaxStrbWidth  = 128;
    localparam int unsigned DefAddrWidth  = 48;
    localparam int unsigned DefDataWidth  = 64;

    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_e;

    typedef struct packed {
        logic [DefAddrWidth-1:0]   addr;
        logic                      write;
        amo_op_e                   amo;
        logic [DefDataWidth-1:0]   data;
        logic [DefDataWidth/8-1:0] strb;
        logic                      user;
    } reqrsp_req_chan_t;

    typedef struct packed {
        reqrsp_req_chan_t q;
        logic             q_valid;
    } reqrsp_req_t;

    typedef struct packed {
        logic [DefDataWidth-1:0] data;
    } reqrsp_rsp_chan_t;

    typedef struct packed {
        reqrsp_rsp_chan_t p;
        logic             p_valid;
        logic             q_ready;
    } reqrsp_rsp_t;

    function automatic logic [31:0] lane_of(input logic [HwpeAddrWidth-1:0] addr,
                                            input int unsigned dw);
        logic [31:0] mask;
        mask = (dw / 32) - 1;
        return (addr >> 2) & mask;
    endfunction

    function automatic logic [MaxStrbWidth-1:0] strb_of(input logic [3:0]  be,
                                                        input logic [31:0] lane,
                                                        input int unsigned dw);
        logic [MaxStrbWidth-1:0] s;
        s = {{(MaxStrbWidth-4){1'b0}}, be} << (lane * 32'd4);
        for (int i = 0; i < int'(MaxStrbWidth); i++) begin
            if (i >= int'(dw / 8)) s[i] = 1'b0;
        end
        return s;
    endfunction

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// HWPE TCDM word port: req/gnt handshake on the request side, r_valid pulse on the response side.
interface hwpe_stream_intf_tcdm;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/fifo_v3.sv
// Generic count-based FIFO; data_o shows the head, one-cycle push-to-visible latency.
// full_o blocks pushes unless a pop happens in the same cycle; pops on empty are ignored.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) mem_q[wr_ptr_q] <= data_i;
        end
    end
endmodule

// File: rtl/snax_hwpe_to_reqrsp_chan.sv
// One bridge channel: queued HWPE words steered onto a wide reqrsp lane, in-order read return.
// gnt is combinational on FIFO space; q_valid waits on both queue data and tracker space.
module snax_hwpe_to_reqrsp_chan
    import snax_hwpe_reqrsp_pkg::*;
#(
    parameter int unsigned AddrWidth      = 48,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned ReqFifoDepth   = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         tcdm_req_t     = reqrsp_req_t,
    parameter type         tcdm_rsp_t     = reqrsp_rsp_t
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_i,
    output logic                     gnt_o,
    input  logic [HwpeAddrWidth-1:0] add_i,
    input  logic                     wen_i,
    input  logic [3:0]               be_i,
    input  logic [HwpeDataWidth-1:0] data_i,
    output logic [HwpeDataWidth-1:0] r_data_o,
    output logic                     r_valid_o,
    output tcdm_req_t                tcdm_req_o,
    input  tcdm_rsp_t                tcdm_rsp_i,
    output logic                     busy_o,
    output logic                     err_o
);
    localparam int unsigned NumLanes = DataWidth / HwpeDataWidth;
    localparam int unsigned LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1;
    localparam int unsigned StrbW    = DataWidth / 8;

    typedef struct packed {
        logic [HwpeAddrWidth-1:0] addr;
        logic                     wen;
        logic [3:0]               be;
        logic [HwpeDataWidth-1:0] data;
    } req_entry_t;

    typedef struct packed {
        logic             is_read;
        logic [LaneW-1:0] lane;
    } meta_t;

    req_entry_t              req_in, req_head;
    meta_t                   meta_in, meta_head;
    logic                    req_full, req_empty, req_push, req_pop;
    logic                    meta_full, meta_empty, meta_push, meta_pop;
    logic                    q_valid, q_hs;
    logic [31:0]             lane_full;
    logic [MaxStrbWidth-1:0] strb_full;
    logic                    err_q, err_d;

    assign gnt_o    = req_i & ~req_full;
    assign req_push = req_i & gnt_o;
    assign req_in   = '{addr: add_i, wen: wen_i, be: be_i, data: data_i};

    fifo_v3 #(
        .DATA_WIDTH ($bits(req_entry_t)),
        .DEPTH      (ReqFifoDepth)
    ) i_req_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (req_push),
        .data_i  (req_in),
        .pop_i   (req_pop),
        .data_o  (req_head),
        .full_o  (req_full),
        .empty_o (req_empty)
    );

    assign lane_full = lane_of(req_head.addr, DataWidth);
    assign strb_full = strb_of(req_head.be, lane_full, DataWidth);

    // A full tracker holds the queue head back so at most MaxOutstanding are in flight.
    assign q_valid   = ~req_empty & ~meta_full;
    assign q_hs      = q_valid & tcdm_rsp_i.q_ready;
    assign req_pop   = q_hs;
    assign meta_push = q_hs;
    assign meta_in   = '{is_read: req_head.wen, lane: LaneW'(lane_full)};

    always_comb begin
        tcdm_req_o         = '0;
        tcdm_req_o.q_valid = q_valid;
        tcdm_req_o.q.addr  = AddrWidth'(req_head.addr);
        tcdm_req_o.q.write = ~req_head.wen;
        tcdm_req_o.q.amo   = AMONone;
        tcdm_req_o.q.data  = {NumLanes{req_head.data}};
        tcdm_req_o.q.strb  = req_head.wen ? {StrbW{1'b1}} : StrbW'(strb_full);
        tcdm_req_o.q.user  = '0;
    end

    fifo_v3 #(
        .DATA_WIDTH ($bits(meta_t)),
        .DEPTH      (MaxOutstanding)
    ) i_meta_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (meta_push),
        .data_i  (meta_in),
        .pop_i   (meta_pop),
        .data_o  (meta_head),
        .full_o  (meta_full),
        .empty_o (meta_empty)
    );

    // Write acknowledgements retire a tracker entry silently; only reads reach the HWPE side.
    assign meta_pop  = tcdm_rsp_i.p_valid & ~meta_empty;
    assign r_valid_o = meta_pop & meta_head.is_read;
    assign r_data_o  = r_valid_o ?
                       tcdm_rsp_i.p.data[HwpeDataWidth*meta_head.lane +: HwpeDataWidth] : '0;

    assign err_d  = err_q | (tcdm_rsp_i.p_valid & meta_empty);
    assign err_o  = err_q;
    assign busy_o = ~req_empty | ~meta_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_d;
    end
endmodule

// File: rtl/snax_hwpe_to_reqrsp_mc.sv
// NumChannels independent HWPE TCDM to reqrsp bridges; no arbitration between channels.
// Each channel grants combinationally and issues one cycle after acceptance at the earliest.
module snax_hwpe_to_reqrsp_mc
    import snax_hwpe_reqrsp_pkg::*;
#(
    parameter int unsigned NumChannels    = 4,
    parameter int unsigned AddrWidth      = 48,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned ReqFifoDepth   = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         tcdm_req_t     = reqrsp_req_t,
    parameter type         tcdm_rsp_t     = reqrsp_rsp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    output tcdm_req_t              tcdm_req_o [NumChannels],
    input  tcdm_rsp_t              tcdm_rsp_i [NumChannels],
    hwpe_stream_intf_tcdm.slave    hwpe_tcdm_slave [NumChannels],
    output logic [NumChannels-1:0] busy_o,
    output logic [NumChannels-1:0] err_o
);
    for (genvar i = 0; i < int'(NumChannels); i++) begin : g_chan
        snax_hwpe_to_reqrsp_chan #(
            .AddrWidth      (AddrWidth),
            .DataWidth      (DataWidth),
            .ReqFifoDepth   (ReqFifoDepth),
            .MaxOutstanding (MaxOutstanding),
            .tcdm_req_t     (tcdm_req_t),
            .tcdm_rsp_t     (tcdm_rsp_t)
        ) i_chan (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .req_i      (hwpe_tcdm_slave[i].req),
            .gnt_o      (hwpe_tcdm_slave[i].gnt),
            .add_i      (hwpe_tcdm_slave[i].add),
            .wen_i      (hwpe_tcdm_slave[i].wen),
            .be_i       (hwpe_tcdm_slave[i].be),
            .data_i     (hwpe_tcdm_slave[i].data),
            .r_data_o   (hwpe_tcdm_slave[i].r_data),
            .r_valid_o  (hwpe_tcdm_slave[i].r_valid),
            .tcdm_req_o (tcdm_req_o[i]),
            .tcdm_rsp_i (tcdm_rsp_i[i]),
            .busy_o     (busy_o[i]),
            .err_o      (err_o[i])
        );
    end
endmodule
